// File: rtl/if_id_stage.sv
// Fetch stage: owns the PC, drives the instruction-memory address and holds the IF/ID register.
// Redirects flush IF/ID. Hazard-unit write enables stall the PC and IF/ID. Saturating counters track stalls and flushes.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_PC_Write,
  input  logic             hz_IF_ID_Write,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      IF_ID_pc,
  output logic [31:0]      IF_ID_pc4,
  output logic [31:0]      IF_ID_inst,
  output logic             IF_ID_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc;
  logic        stall_hit;

  assign imem_addr = pc;
  assign IF_ID_pc4 = IF_ID_pc + 32'd4;
  // A held bubble is not counted as a stall; only a real instruction being frozen counts.
  assign stall_hit = !redirect_valid && !hz_IF_ID_Write && IF_ID_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc <= RESET_PC;
    else if (redirect_valid) pc <= {redirect_pc[31:2], 2'b00};
    else if (hz_PC_Write)    pc <= pc + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IF_ID_pc    <= 32'd0;
      IF_ID_inst  <= NOP;
      IF_ID_valid <= 1'b0;
    end else if (redirect_valid) begin
      IF_ID_pc    <= 32'd0;
      IF_ID_inst  <= NOP;
      IF_ID_valid <= 1'b0;
    end else if (hz_IF_ID_Write) begin
      IF_ID_pc    <= pc;
      IF_ID_inst  <= imem_rdata;
      IF_ID_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_hit && stall_cnt != '1)      stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect_valid && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: a default instance driven from a vector table through a scoreboard queue,
// plus a wrapped-PC / 3-bit-counter instance for the wrap and saturation corners.
module tb_if_id_stage;
  localparam logic [31:0] K   = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rst_w = 1'b1;
  logic        pcw = 1'b0, ifw = 1'b0, rv = 1'b0;
  logic [31:0] rpc = 32'd0;

  logic [31:0] addr, rdata, id_pc, id_pc4, id_inst;
  logic        id_vld;
  logic [31:0] scnt, fcnt;
  logic [31:0] addr_w, rdata_w, id_pc_w, id_pc4_w, id_inst_w;
  logic        id_vld_w;
  logic [2:0]  scnt_w, fcnt_w;

  int total = 0, bad = 0;

  assign rdata   = addr ^ K;
  assign rdata_w = addr_w ^ K;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk(clk), .rst(rst), .hz_PC_Write(pcw), .hz_IF_ID_Write(ifw),
    .redirect_valid(rv), .redirect_pc(rpc), .imem_addr(addr), .imem_rdata(rdata),
    .IF_ID_pc(id_pc), .IF_ID_pc4(id_pc4), .IF_ID_inst(id_inst), .IF_ID_valid(id_vld),
    .stall_cnt(scnt), .flush_cnt(fcnt)
  );

  if_id_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(3)) dut_w (
    .clk(clk), .rst(rst_w), .hz_PC_Write(pcw), .hz_IF_ID_Write(ifw),
    .redirect_valid(rv), .redirect_pc(rpc), .imem_addr(addr_w), .imem_rdata(rdata_w),
    .IF_ID_pc(id_pc_w), .IF_ID_pc4(id_pc4_w), .IF_ID_inst(id_inst_w), .IF_ID_valid(id_vld_w),
    .stall_cnt(scnt_w), .flush_cnt(fcnt_w)
  );

  typedef struct {
    logic        pcw, ifw, rv;
    logic [31:0] rpc;
    logic [31:0] e_addr, e_pc;
    logic        e_vld;
    logic [31:0] e_stall, e_flush;
  } vec_t;

  vec_t vt[15];
  vec_t sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_main(input string tag, input vec_t e);
    check({tag, " imem_addr"}, addr, e.e_addr);
    check({tag, " IF_ID_pc"}, id_pc, e.e_pc);
    check({tag, " IF_ID_pc4"}, id_pc4, e.e_pc + 32'd4);
    check({tag, " IF_ID_inst"}, id_inst, e.e_vld ? (e.e_pc ^ K) : NOP);
    check({tag, " IF_ID_valid"}, {31'd0, id_vld}, {31'd0, e.e_vld});
    check({tag, " stall_cnt"}, scnt, e.e_stall);
    check({tag, " flush_cnt"}, fcnt, e.e_flush);
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    pcw = v.pcw; ifw = v.ifw; rv = v.rv; rpc = v.rpc;
    sbq.push_back(v);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check_main("vec", e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //          pcw   ifw   rv    rpc           addr          ifid_pc       vld   stall  flush
    vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,       32'h4,        32'h0,        1'b1, 32'd0, 32'd0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,       32'h8,        32'h4,        1'b1, 32'd0, 32'd0};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,       32'hC,        32'h8,        1'b1, 32'd0, 32'd0};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,       32'h10,       32'hC,        1'b1, 32'd0, 32'd0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,       32'h10,       32'hC,        1'b1, 32'd1, 32'd0};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,       32'h14,       32'h10,       1'b1, 32'd1, 32'd0};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,       32'h18,       32'h14,       1'b1, 32'd1, 32'd0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 32'h203,     32'h200,      32'h0,        1'b0, 32'd1, 32'd1};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,       32'h200,      32'h0,        1'b0, 32'd1, 32'd1};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,       32'h204,      32'h200,      1'b1, 32'd1, 32'd1};
    vt[10] = '{1'b1, 1'b0, 1'b0, 32'h0,       32'h208,      32'h200,      1'b1, 32'd2, 32'd1};
    vt[11] = '{1'b0, 1'b1, 1'b0, 32'h0,       32'h208,      32'h208,      1'b1, 32'd2, 32'd1};
    vt[12] = '{1'b0, 1'b1, 1'b0, 32'h0,       32'h208,      32'h208,      1'b1, 32'd2, 32'd1};
    vt[13] = '{1'b1, 1'b1, 1'b1, 32'h102,     32'h100,      32'h0,        1'b0, 32'd2, 32'd2};
    vt[14] = '{1'b1, 1'b1, 1'b0, 32'h0,       32'h104,      32'h100,      1'b1, 32'd2, 32'd2};

    // Reset state while rst is held across an edge
    repeat (2) @(negedge clk);
    check("rst imem_addr", addr, 32'h0);
    check("rst IF_ID_pc", id_pc, 32'h0);
    check("rst IF_ID_inst", id_inst, NOP);
    check("rst IF_ID_valid", {31'd0, id_vld}, 32'd0);
    check("rst stall_cnt", scnt, 32'd0);
    check("rst flush_cnt", fcnt, 32'd0);
    check("rst_w imem_addr", addr_w, 32'hFFFF_FFF8);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) apply(vt[i]);

    // Redirect to 0x40, then async reset between edges with a redirect pending
    apply('{1'b1, 1'b1, 1'b1, 32'h40, 32'h40, 32'h0, 1'b0, 32'd2, 32'd3});
    @(negedge clk);
    rv = 1'b1; rpc = 32'h300; pcw = 1'b1; ifw = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("async imem_addr", addr, 32'h0);
    check("async IF_ID_valid", {31'd0, id_vld}, 32'd0);
    check("async IF_ID_inst", id_inst, NOP);
    check("async stall_cnt", scnt, 32'd0);
    check("async flush_cnt", fcnt, 32'd0);
    @(posedge clk); #1;
    check("rst hold imem_addr", addr, 32'h0);
    check("rst hold flush_cnt", fcnt, 32'd0);
    @(negedge clk);
    rv = 1'b0; rpc = 32'h0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post-rst IF_ID_pc", id_pc, 32'h0);
    check("post-rst IF_ID_valid", {31'd0, id_vld}, 32'd1);
    check("post-rst IF_ID_inst", id_inst, K);
    check("post-rst imem_addr", addr, 32'h4);
    check("post-rst flush_cnt", fcnt, 32'd0);

    // Wrap on the second instance
    @(negedge clk);
    pcw = 1'b1; ifw = 1'b1; rv = 1'b0;
    rst_w = 1'b0;
    check("wrap start addr", addr_w, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    check("wrap1 addr", addr_w, 32'hFFFF_FFFC);
    check("wrap1 IF_ID_pc", id_pc_w, 32'hFFFF_FFF8);
    check("wrap1 IF_ID_pc4", id_pc4_w, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap2 addr", addr_w, 32'h0);
    check("wrap2 IF_ID_pc", id_pc_w, 32'hFFFF_FFFC);
    check("wrap2 IF_ID_pc4", id_pc4_w, 32'h0);
    check("wrap2 IF_ID_inst", id_inst_w, 32'hFFFF_FFFC ^ K);

    // Stall saturation on a 3-bit counter
    @(negedge clk);
    pcw = 1'b0; ifw = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("sat stall_cnt c%0d", i), {29'd0, scnt_w}, (i > 7) ? 32'd7 : 32'(i));
    end
    check("sat IF_ID_pc held", id_pc_w, 32'hFFFF_FFFC);
    check("sat imem_addr held", addr_w, 32'h0);

    // Flush saturation on a 3-bit counter
    @(negedge clk);
    rv = 1'b1; rpc = 32'h80;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk); #1;
      check($sformatf("sat flush_cnt c%0d", i), {29'd0, fcnt_w}, (i > 7) ? 32'd7 : 32'(i));
    end
    check("sat stall_cnt stays", {29'd0, scnt_w}, 32'd7);
    check("flush IF_ID_valid", {31'd0, id_vld_w}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Front-end fetch stage that consumes the load-use stall controls (hz_PC_Write, hz_IF_ID_Write) produced by the hazard unit. It owns the PC register, drives the instruction-memory address, and holds the IF/ID pipeline register. It also applies branch/jump redirects with flush, and keeps saturating stall and flush event counters for performance debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
CNT_W, 32, width of the stall_cnt and flush_cnt counters.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
hz_PC_Write  input  1  1 = PC may advance this cycle
hz_IF_ID_Write  input  1  1 = IF/ID register may load this cycle
redirect_valid  input  1  taken branch/jump resolved downstream; flush request
redirect_pc  input  32  redirect target address
imem_addr  output  32  instruction memory address, combinational from PC
imem_rdata  input  32  instruction word for imem_addr, same-cycle (asynchronous read)
IF_ID_pc  output  32  PC of the held instruction
IF_ID_pc4  output  32  IF_ID_pc + 4
IF_ID_inst  output  32  held instruction word
IF_ID_valid  output  1  1 = held instruction is real, 0 = bubble
stall_cnt  output  CNT_W  saturating count of stall cycles
flush_cnt  output  CNT_W  saturating count of redirect cycles

Behaviour:
- Reset (async, immediate on rst=1, independent of clk):
  - PC=RESET_PC
  - IF_ID_pc=0, IF_ID_inst=32'h0000_0013 (NOP), IF_ID_valid=0
  - stall_cnt=0, flush_cnt=0
  - All state holds while rst=1.
  - After rst deasserts, the first rising edge fetches RESET_PC.
- imem_addr = PC, combinational.
- IF_ID_pc4 = IF_ID_pc + 4, combinational, modulo 2^32.
- PC update on each rising edge, in priority order:
  1. redirect_valid=1: PC <= {redirect_pc[31:2],2'b00}. Low bits are forced to 0. Hazard inputs are ignored.
  2. else if hz_PC_Write=1: PC <= PC+4. Wraps 32'hFFFF_FFFC -> 0 with no flag.
  3. else: PC holds.
- IF/ID update on each rising edge, in priority order:
  1. redirect_valid=1: flush. IF_ID_inst <= NOP, IF_ID_valid <= 0, IF_ID_pc <= 0. Flush wins over a simultaneous stall.
  2. else if hz_IF_ID_Write=1: IF_ID_pc <= PC, IF_ID_inst <= imem_rdata, IF_ID_valid <= 1.
  3. else: all IF/ID fields hold (stall).
- Latency: an instruction fetched at edge N appears on the IF_ID_* outputs after edge N. It stays there for as many cycles as hz_IF_ID_Write=0.
- Load-use stall: one cycle with hz_PC_Write=0 and hz_IF_ID_Write=0 holds PC and IF/ID for exactly one cycle. The bubble itself is inserted downstream.
- Mismatched controls are legal and defined, with no error flag:
  - hz_PC_Write=1, hz_IF_ID_Write=0: PC advances and IF/ID holds, so the skipped word is dropped.
  - hz_PC_Write=0, hz_IF_ID_Write=1: IF/ID reloads the same PC.
- stall_cnt: +1 on an edge where redirect_valid=0, hz_IF_ID_Write=0 and IF_ID_valid=1. Saturates at all-ones.
- flush_cnt: +1 on each edge with redirect_valid=1. Saturates at all-ones.
- Both counters increment in the same cycle's edge as their event. Neither counter has a synchronous clear.
- Reset mid-stall or mid-redirect: outputs take reset values at once, and no pending redirect or stall survives reset.

Test Plan:
- Reset then free-run, hz_*=1, imem_rdata=addr^32'hA5A5_0000 -> IF_ID_pc sequence 0,4,8,... with matching inst, IF_ID_valid=1 from first edge, counters stay 0.
- Load-use stall, both hz_*=0 for 1 cycle at PC=0x10 -> PC stays 0x10 one extra cycle, IF_ID_pc stays 0x0C two cycles, stall_cnt=1, next fetch 0x10.
- Redirect during stall: hz_*=0 and redirect_valid=1 with redirect_pc=0x203 -> PC=0x200, IF_ID_valid=0 with inst=NOP, flush_cnt=1, stall_cnt unchanged.
- Wrap: RESET_PC=32'hFFFF_FFF8, free-run -> PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; IF_ID_pc4 for FFFF_FFFC reads 0.
- Saturation with CNT_W=3: hold hz_*=0 for 10 cycles with a valid instruction -> stall_cnt reaches 7 and stays 7.
- Async reset mid-operation: assert rst between clock edges at PC=0x40 -> PC=RESET_PC, IF_ID_valid=0, counters 0 before the next edge.
